// File: rtl/renkon_ctrl_conv.sv
// Sequencer for renkon_conv: streams one kernel and one image plane per input channel,
// marks completed windows and issues delayed output-buffer writes for the last channel.
module renkon_ctrl_conv #(
   parameter int FSIZE    = 5,
   parameter int CONV_LAT = 3,
   parameter int LWIDTH   = 8,
   parameter int IMGADDR  = 16,
   parameter int WTADDR   = 12,
   parameter int OUTADDR  = 12
) (
   input  logic                              clk,
   input  logic                              xrst,
   input  logic                              req,
   input  logic [LWIDTH-1:0]                 img_size,
   input  logic [LWIDTH-1:0]                 n_in,
   output logic                              ack,
   output logic                              mem_img_en,
   output logic [IMGADDR-1:0]                mem_img_addr,
   output logic                              mem_wt_en,
   output logic [WTADDR-1:0]                 mem_wt_addr,
   output logic                              conv_wt_we,
   output logic [$clog2(FSIZE*FSIZE)-1:0]    conv_wt_idx,
   output logic                              conv_pix_valid,
   output logic                              conv_win_valid,
   output logic                              conv_acc_first,
   output logic                              out_we,
   output logic [OUTADDR-1:0]                out_addr
);

   localparam int unsigned KSZ  = FSIZE * FSIZE;
   localparam int          IDXW = $clog2(FSIZE * FSIZE);
   localparam int          DW   = $clog2(CONV_LAT + 2);

   typedef enum logic [1:0] {IDLE, WEIGHT, IMAGE, DRAIN} state_t;

   state_t              state, nxt;
   logic [LWIDTH-1:0]   sz, n, ch, row, col;
   logic [IDXW-1:0]     wcnt;
   logic [DW-1:0]       dcnt;
   logic [WTADDR-1:0]   wt_addr;
   logic [IMGADDR-1:0]  img_addr;
   logic [CONV_LAT:0]   out_pipe;
   logic                start, wt_last, img_last, ch_last, win_issue;

   assign start     = (state == IDLE) && req;
   assign wt_last   = (wcnt == IDXW'(KSZ - 1));
   assign img_last  = (row == sz - 1'b1) && (col == sz - 1'b1);
   assign ch_last   = (ch == n - 1'b1);
   assign win_issue = (state == IMAGE) && (row >= LWIDTH'(FSIZE - 1)) && (col >= LWIDTH'(FSIZE - 1));

   assign mem_wt_addr  = wt_addr;
   assign mem_img_addr = img_addr;
   assign out_we       = out_pipe[CONV_LAT];

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt        = state;
      ack        = 1'b0;
      mem_wt_en  = 1'b0;
      mem_img_en = 1'b0;
      case (state)
         IDLE: begin
            ack = 1'b1;
            if (req) nxt = WEIGHT;
         end
         WEIGHT: begin
            mem_wt_en = 1'b1;
            if (wt_last) nxt = IMAGE;
         end
         IMAGE: begin
            mem_img_en = 1'b1;
            if (img_last) nxt = ch_last ? DRAIN : WEIGHT;
         end
         DRAIN: if (dcnt == DW'(CONV_LAT)) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Address counters run continuously across channels; only a new request rewinds them.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         sz       <= '0;
         n        <= '0;
         ch       <= '0;
         row      <= '0;
         col      <= '0;
         wcnt     <= '0;
         dcnt     <= '0;
         wt_addr  <= '0;
         img_addr <= '0;
      end else begin
         if (start) begin
            sz       <= img_size;
            n        <= n_in;
            ch       <= '0;
            row      <= '0;
            col      <= '0;
            wcnt     <= '0;
            dcnt     <= '0;
            wt_addr  <= '0;
            img_addr <= '0;
         end
         if (state == WEIGHT) begin
            wt_addr <= wt_addr + 1'b1;
            wcnt    <= wt_last ? '0 : wcnt + 1'b1;
         end
         if (state == IMAGE) begin
            img_addr <= img_addr + 1'b1;
            if (col == sz - 1'b1) begin
               col <= '0;
               row <= img_last ? '0 : row + 1'b1;
               if (img_last && !ch_last) ch <= ch + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         if (state == DRAIN) dcnt <= dcnt + 1'b1;
      end
   end

   // Issue-cycle flags are registered once to line up with the 1-cycle RAM read data.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         conv_wt_we     <= 1'b0;
         conv_wt_idx    <= '0;
         conv_pix_valid <= 1'b0;
         conv_win_valid <= 1'b0;
         conv_acc_first <= 1'b0;
         out_pipe       <= '0;
         out_addr       <= '0;
      end else begin
         conv_wt_we     <= (state == WEIGHT);
         conv_wt_idx    <= wcnt;
         conv_pix_valid <= (state == IMAGE);
         conv_win_valid <= win_issue;
         conv_acc_first <= win_issue && (ch == '0);
         out_pipe       <= {out_pipe[CONV_LAT-1:0], win_issue && ch_last};
         if (start)       out_addr <= '0;
         else if (out_we) out_addr <= out_addr + 1'b1;
      end
   end

endmodule

// File: tb/tb_renkon_ctrl_conv.sv
// Scoreboard bench for renkon_ctrl_conv: runs push timed expected events, a monitor pops them.
module tb_renkon_ctrl_conv;

   localparam int F  = 5;
   localparam int CL = 3;
   localparam int KK = F * F;

   logic        clk = 1'b0;
   logic        xrst = 1'b0;
   logic        req = 1'b0;
   logic [7:0]  img_size = '0;
   logic [7:0]  n_in = '0;
   logic        ack, mem_img_en, mem_wt_en, conv_wt_we, conv_pix_valid;
   logic        conv_win_valid, conv_acc_first, out_we;
   logic [15:0] mem_img_addr;
   logic [11:0] mem_wt_addr, out_addr;
   logic [4:0]  conv_wt_idx;

   renkon_ctrl_conv #(
      .FSIZE(F), .CONV_LAT(CL), .LWIDTH(8), .IMGADDR(16), .WTADDR(12), .OUTADDR(12)
   ) dut (
      .clk(clk), .xrst(xrst), .req(req), .img_size(img_size), .n_in(n_in), .ack(ack),
      .mem_img_en(mem_img_en), .mem_img_addr(mem_img_addr),
      .mem_wt_en(mem_wt_en), .mem_wt_addr(mem_wt_addr),
      .conv_wt_we(conv_wt_we), .conv_wt_idx(conv_wt_idx),
      .conv_pix_valid(conv_pix_valid), .conv_win_valid(conv_win_valid),
      .conv_acc_first(conv_acc_first), .out_we(out_we), .out_addr(out_addr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int t; int v; } ev_t;
   ev_t wa_q[$], ia_q[$], wt_q[$], px_q[$], win_q[$], out_q[$];

   int checks = 0;
   int passes = 0;

   task automatic chk(input string nm, input int at, input int av, input int et, input int ev);
      checks++;
      if (at == et && av == ev) passes++;
      else $display("FAIL %s: got cycle=%0d value=%0d, expected cycle=%0d value=%0d", nm, at, av, et, ev);
   endtask

   function automatic int any_out();
      return int'(mem_img_en | (|mem_img_addr) | mem_wt_en | (|mem_wt_addr) | conv_wt_we |
                  (|conv_wt_idx) | conv_pix_valid | conv_win_valid | conv_acc_first |
                  out_we | (|out_addr));
   endfunction

   function automatic int pending();
      return wa_q.size() + ia_q.size() + wt_q.size() + px_q.size() + win_q.size() + out_q.size();
   endfunction

   always @(negedge clk) begin : monitor
      ev_t e;
      if (xrst) begin
         if (mem_wt_en) begin
            if (wa_q.size() == 0) chk("wt_addr extra", cyc, int'(mem_wt_addr), -1, -1);
            else begin e = wa_q.pop_front(); chk("wt_addr", cyc, int'(mem_wt_addr), e.t, e.v); end
         end
         if (mem_img_en) begin
            if (ia_q.size() == 0) chk("img_addr extra", cyc, int'(mem_img_addr), -1, -1);
            else begin e = ia_q.pop_front(); chk("img_addr", cyc, int'(mem_img_addr), e.t, e.v); end
         end
         if (conv_wt_we) begin
            if (wt_q.size() == 0) chk("wt_idx extra", cyc, int'(conv_wt_idx), -1, -1);
            else begin e = wt_q.pop_front(); chk("wt_idx", cyc, int'(conv_wt_idx), e.t, e.v); end
         end
         if (conv_pix_valid) begin
            if (px_q.size() == 0) chk("pix extra", cyc, 1, -1, -1);
            else begin e = px_q.pop_front(); chk("pix_valid", cyc, 1, e.t, e.v); end
         end
         if (conv_win_valid) begin
            if (win_q.size() == 0) chk("win extra", cyc, int'(conv_acc_first), -1, -1);
            else begin e = win_q.pop_front(); chk("win/acc_first", cyc, int'(conv_acc_first), e.t, e.v); end
         end
         if (conv_acc_first && !conv_win_valid) chk("acc_first stray", cyc, 1, cyc, 0);
         if (out_we) begin
            if (out_q.size() == 0) chk("out extra", cyc, int'(out_addr), -1, -1);
            else begin e = out_q.pop_front(); chk("out_addr", cyc, int'(out_addr), e.t, e.v); end
         end
      end
   end

   // Called at a negedge; b is the first busy sample (state WEIGHT, wt_addr 0).
   task automatic start_run(input int s, input int n, output int b);
      int p;
      int oa;
      p  = KK + s * s;
      oa = 0;
      b  = cyc + 1;
      for (int c = 0; c < n; c++) begin
         for (int k = 0; k < KK; k++) begin
            wa_q.push_back('{b + c * p + k, c * KK + k});
            wt_q.push_back('{b + c * p + 1 + k, k});
         end
         for (int i = 0; i < s * s; i++) begin
            ia_q.push_back('{b + c * p + KK + i, c * s * s + i});
            px_q.push_back('{b + c * p + KK + 1 + i, 1});
            if ((i / s) >= F - 1 && (i % s) >= F - 1) begin
               win_q.push_back('{b + c * p + KK + 1 + i, (c == 0) ? 1 : 0});
               if (c == n - 1) begin
                  out_q.push_back('{b + c * p + KK + 1 + CL + i, oa});
                  oa++;
               end
            end
         end
      end
      img_size = 8'(s);
      n_in     = 8'(n);
      req      = 1'b1;
      @(negedge clk);
      req      = 1'b0;
      img_size = 8'hff;
      n_in     = 8'h07;
      chk("ack low after req", cyc, int'(ack), b, 0);
   endtask

   task automatic wait_done(input int b, input int s, input int n);
      int total;
      int k;
      total = n * (KK + s * s);
      k = 0;
      while (!ack && k < total + 50) begin
         @(negedge clk);
         k++;
      end
      if (ack) chk("ack return", cyc, 1, b + total + CL + 1, 1);
      else     chk("ack timeout", cyc, 0, b + total + CL + 1, 1);
      chk("scoreboard drained", 0, pending(), 0, 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int b;
      repeat (3) @(negedge clk);
      chk("reset ack", 0, int'(ack), 0, 1);
      chk("reset outputs", 0, any_out(), 0, 0);
      xrst = 1'b1;
      repeat (2) @(negedge clk);

      start_run(12, 1, b);          // single channel
      wait_done(b, 12, 1);
      @(negedge clk);

      start_run(8, 3, b);           // three channels
      wait_done(b, 8, 3);
      @(negedge clk);

      start_run(5, 1, b);           // minimum image
      wait_done(b, 5, 1);
      @(negedge clk);

      start_run(8, 2, b);           // req while busy is ignored
      repeat (40) @(negedge clk);
      img_size = 8'd12;
      n_in     = 8'd1;
      req      = 1'b1;
      @(negedge clk);
      req = 1'b0;
      wait_done(b, 8, 2);

      start_run(6, 1, b);           // back-to-back on ack rise
      wait_done(b, 6, 1);
      start_run(5, 2, b);
      wait_done(b, 5, 2);
      @(negedge clk);

      start_run(8, 2, b);           // reset during channel 0 image phase
      repeat (35) @(negedge clk);
      #1 xrst = 1'b0;
      #1;
      chk("async reset ack", cyc, int'(ack), cyc, 1);
      chk("async reset outputs", cyc, any_out(), cyc, 0);
      wa_q.delete(); ia_q.delete(); wt_q.delete();
      px_q.delete(); win_q.delete(); out_q.delete();
      @(negedge clk);
      #1 xrst = 1'b1;
      @(negedge clk);
      start_run(8, 2, b);
      wait_done(b, 8, 2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
